// File: rtl/fec_pkg.sv
// Shared FEC types and constants for the uplink FEC controller.
package fec_pkg;

  localparam int unsigned UL_BYTES_PER_FRAME = 7;
  localparam int unsigned UL_HDR_LEN_LSB     = 0;
  localparam int unsigned UL_FEC_TO_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LATCH = 3'd2,
    S_DEC   = 3'd3,
    S_RESP  = 3'd4,
    S_OUT   = 3'd5
  } ul_fec_state_t;

endpackage

// File: rtl/ul_fec_err_stats.sv
// Saturating corrected / uncorrectable frame counters.
module ul_fec_err_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cor_inc_i,
  input  logic        uncor_inc_i,
  output logic [15:0] cor_cnt_o,
  output logic [15:0] uncor_cnt_o
);

  localparam int unsigned CW = 16;

  logic [CW-1:0] cor_q;
  logic [CW-1:0] uncor_q;

  // Count one event per pulse, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cor_q   <= '0;
      uncor_q <= '0;
    end else begin
      if (cor_inc_i && (cor_q != '1))     cor_q   <= cor_q + CW'(1);
      if (uncor_inc_i && (uncor_q != '1)) uncor_q <= uncor_q + CW'(1);
    end
  end

  assign cor_cnt_o   = cor_q;
  assign uncor_cnt_o = uncor_q;

endmodule

// File: rtl/ul_fec_ctrl.sv
// Uplink FEC controller: pops monitor frames, drives the header/data decoder,
// tracks message length and streams decoded beats to the host.
// Optional error counters: define UL_FEC_ERR_STATS_EN.
module ul_fec_ctrl
  import fec_pkg::*;
#(
  parameter int unsigned DW   = 56,
  parameter int unsigned LW   = 8,
  parameter int unsigned FAW  = 2,
  parameter int unsigned TO_W = UL_FEC_TO_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [FAW-1:0] mon_level,
  output logic           mon_rd,
  input  logic           mon_enc_used,
  input  logic [DW-1:0]  mon_data,
  input  logic [7:0]     mon_crc,
  input  logic [7:0]     mon_row_p,
  input  logic [7:0]     mon_col_p,
  output logic           dec_start,
  output logic           dec_sel,
  output logic [DW-1:0]  dec_data,
  output logic [7:0]     dec_crc,
  output logic [7:0]     dec_row_p,
  output logic [7:0]     dec_col_p,
  input  logic           dec_done,
  input  logic [DW-1:0]  dec_out,
  input  logic           dec_cor,
  input  logic           dec_uncor,
  output logic           fec_done,
  output logic           fec_uncor_err,
  output logic           msg_done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic [2:0]     out_nbytes,
  output logic           out_hdr,
  output logic           out_last,
  output logic           out_err,
  output logic [15:0]    cor_cnt,
  output logic [15:0]    uncor_cnt
);

  ul_fec_state_t state_q, state_d;

  logic           enc_q;
  logic [DW-1:0]  dec_data_q, dec_data_d;
  logic [7:0]     dec_crc_q, dec_crc_d, dec_row_q, dec_row_d, dec_col_q, dec_col_d;
  logic           enc_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic           mon_rd_q, mon_rd_d, dec_start_q, dec_start_d;
  logic           fec_done_q, fec_done_d, fec_uncor_q, fec_uncor_d;
  logic           msg_done_q, msg_done_d, drop_q, drop_d;
  logic [LW-1:0]  rem_len_q, rem_len_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic [2:0]     out_nbytes_q, out_nbytes_d;
  logic           out_hdr_q, out_hdr_d, out_last_q, out_last_d, out_err_q, out_err_d;

  logic [TO_W-1:0] to_inc;
  logic           to_hit, dec_fin, eff_uncor, eff_cor, mismatch, drop;
  logic [LW-1:0]  hdr_len, rem_new;
  logic [2:0]     n_c;
  logic           stat_cor_c, stat_uncor_c;

  // Decode outcome classification; a real decoder result beats a timeout.
  assign to_inc    = to_cnt_q + TO_W'(1);
  assign to_hit    = &to_inc;
  assign dec_fin   = (state_q == S_DEC) && (dec_done || to_hit);
  assign eff_uncor = dec_done ? dec_uncor : 1'b1;
  assign eff_cor   = dec_done & dec_cor;
  assign mismatch  = (enc_q != msg_done_q);
  assign drop      = mismatch || (enc_q && eff_uncor);
  assign hdr_len   = dec_out[UL_HDR_LEN_LSB +: LW];
  assign n_c       = (rem_len_q >= LW'(UL_BYTES_PER_FRAME)) ? 3'(UL_BYTES_PER_FRAME)
                                                            : rem_len_q[2:0];
  assign rem_new   = rem_len_q - LW'(n_c);
  assign stat_cor_c   = dec_fin && !mismatch && eff_cor;
  assign stat_uncor_c = dec_fin && (mismatch || eff_uncor);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mon_level != '0) state_d = S_POP;
      S_POP:   state_d = S_LATCH;
      S_LATCH: state_d = S_DEC;
      S_DEC:   if (dec_fin) state_d = S_RESP;
      S_RESP:  state_d = drop_q ? S_IDLE : S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    enc_d        = enc_q;
    dec_data_d   = dec_data_q;
    dec_crc_d    = dec_crc_q;
    dec_row_d    = dec_row_q;
    dec_col_d    = dec_col_q;
    to_cnt_d     = to_cnt_q;
    msg_done_d   = msg_done_q;
    rem_len_d    = rem_len_q;
    drop_d       = drop_q;
    out_data_d   = out_data_q;
    out_nbytes_d = out_nbytes_q;
    out_hdr_d    = out_hdr_q;
    out_last_d   = out_last_q;
    out_err_d    = out_err_q;
    mon_rd_d     = (state_d == S_POP);
    dec_start_d  = (state_d == S_DEC) && (state_q != S_DEC);
    fec_done_d   = (state_d == S_RESP);
    out_valid_d  = (state_d == S_OUT);
    fec_uncor_d  = 1'b0;

    if (state_q == S_LATCH) begin
      enc_d      = mon_enc_used;
      dec_data_d = mon_data;
      dec_crc_d  = mon_crc;
      dec_row_d  = mon_enc_used ? {4'h0, mon_row_p[3:0]} : mon_row_p;
      dec_col_d  = mon_enc_used ? {4'h0, mon_col_p[3:0]} : mon_col_p;
      to_cnt_d   = '0;
    end else if (state_q == S_DEC) begin
      to_cnt_d = to_inc;
    end

    if (dec_fin) begin
      drop_d      = drop;
      fec_uncor_d = drop;
      if (mismatch) begin
        msg_done_d = 1'b1;
        rem_len_d  = '0;
      end else if (enc_q) begin
        if (!eff_uncor) begin
          rem_len_d    = hdr_len;
          msg_done_d   = (hdr_len == '0);
          out_data_d   = dec_out;
          out_nbytes_d = 3'd0;
          out_hdr_d    = 1'b1;
          out_last_d   = (hdr_len == '0);
          out_err_d    = 1'b0;
        end
      end else begin
        rem_len_d    = rem_new;
        msg_done_d   = (rem_new == '0);
        out_data_d   = dec_out;
        out_nbytes_d = n_c;
        out_hdr_d    = 1'b0;
        out_last_d   = (rem_new == '0);
        out_err_d    = eff_uncor;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      enc_q        <= 1'b0;
      dec_data_q   <= '0;
      dec_crc_q    <= '0;
      dec_row_q    <= '0;
      dec_col_q    <= '0;
      to_cnt_q     <= '0;
      mon_rd_q     <= 1'b0;
      dec_start_q  <= 1'b0;
      fec_done_q   <= 1'b0;
      fec_uncor_q  <= 1'b0;
      msg_done_q   <= 1'b1;
      rem_len_q    <= '0;
      drop_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_nbytes_q <= '0;
      out_hdr_q    <= 1'b0;
      out_last_q   <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      enc_q        <= enc_d;
      dec_data_q   <= dec_data_d;
      dec_crc_q    <= dec_crc_d;
      dec_row_q    <= dec_row_d;
      dec_col_q    <= dec_col_d;
      to_cnt_q     <= to_cnt_d;
      mon_rd_q     <= mon_rd_d;
      dec_start_q  <= dec_start_d;
      fec_done_q   <= fec_done_d;
      fec_uncor_q  <= fec_uncor_d;
      msg_done_q   <= msg_done_d;
      rem_len_q    <= rem_len_d;
      drop_q       <= drop_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_nbytes_q <= out_nbytes_d;
      out_hdr_q    <= out_hdr_d;
      out_last_q   <= out_last_d;
      out_err_q    <= out_err_d;
    end
  end

  assign mon_rd        = mon_rd_q;
  assign dec_start     = dec_start_q;
  assign dec_sel       = enc_q;
  assign dec_data      = dec_data_q;
  assign dec_crc       = dec_crc_q;
  assign dec_row_p     = dec_row_q;
  assign dec_col_p     = dec_col_q;
  assign fec_done      = fec_done_q;
  assign fec_uncor_err = fec_uncor_q;
  assign msg_done      = msg_done_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_nbytes    = out_nbytes_q;
  assign out_hdr       = out_hdr_q;
  assign out_last      = out_last_q;
  assign out_err       = out_err_q;

`ifdef UL_FEC_ERR_STATS_EN
  logic stat_cor_q, stat_uncor_q;

  // Stat pulses land in RESP so the counters step once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cor_q   <= 1'b0;
      stat_uncor_q <= 1'b0;
    end else begin
      stat_cor_q   <= stat_cor_c;
      stat_uncor_q <= stat_uncor_c;
    end
  end

  ul_fec_err_stats u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .cor_inc_i   (stat_cor_q),
    .uncor_inc_i (stat_uncor_q),
    .cor_cnt_o   (cor_cnt),
    .uncor_cnt_o (uncor_cnt)
  );
`else
  logic unused_stats;
  assign unused_stats = stat_cor_c ^ stat_uncor_c;
  assign cor_cnt      = '0;
  assign uncor_cnt    = '0;
`endif

endmodule
